// File: rtl/mem_dma_master_if.sv
// Memory-side bus between the DMA master and the 8-bit data memory / MMIO responder.
// Read data M_Q is combinational and valid in the same cycle M_ADDR is driven.
interface mem_dma_master_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic [AW-1:0] M_ADDR;
  logic [DW-1:0] M_DATA;
  logic          M_MW;
  logic [DW-1:0] M_Q;

  modport master (output M_ADDR, output M_DATA, output M_MW, input M_Q);
  modport slave  (input M_ADDR, input M_DATA, input M_MW, output M_Q);
endinterface

// File: rtl/mem_dma_master.sv
// Block copy engine: copies LEN bytes SRC->DST as one read cycle then one write cycle
// per byte, with optional fixed addresses for port streaming.
module mem_dma_master #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int IO_RO_LO = 249,
  parameter int IO_RO_HI = 251
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          START,
  input  logic          ABORT,
  input  logic [AW-1:0] SRC,
  input  logic [AW-1:0] DST,
  input  logic [AW-1:0] LEN,
  input  logic          SRC_INC,
  input  logic          DST_INC,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output logic [AW-1:0] COUNT,
  mem_dma_master_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

  localparam logic [AW-1:0] RO_LO = AW'(IO_RO_LO);
  localparam logic [AW-1:0] RO_HI = AW'(IO_RO_HI);
  localparam logic [AW-1:0] ONE   = AW'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d, rem_q, rem_d, cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          err_q, err_d, abort_q, abort_d;
  logic          sinc_q, sinc_d, dinc_q, dinc_d;
  logic          dst_ro, mw;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      sinc_q  <= 1'b0;
      dinc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      sinc_q  <= sinc_d;
      dinc_q  <= dinc_d;
    end
  end

  assign dst_ro = (dst_q >= RO_LO) && (dst_q <= RO_HI);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    abort_d = abort_q;
    sinc_d  = sinc_q;
    dinc_d  = dinc_q;
    addr_d  = addr_q;
    mw      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          src_d   = SRC;
          dst_d   = DST;
          rem_d   = LEN;
          sinc_d  = SRC_INC;
          dinc_d  = DST_INC;
          cnt_d   = '0;
          err_d   = 1'b0;
          abort_d = 1'b0;
          state_d = (LEN == '0) ? S_FIN : S_RD;
        end
      end
      S_RD: begin
        addr_d  = src_q;
        data_d  = bus.M_Q;
        abort_d = abort_q | ABORT;
        state_d = S_WR;
      end
      S_WR: begin
        addr_d = dst_q;
        if (dst_ro) begin
          // Read-only input port: suppress the strobe and stop with an error.
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          mw    = 1'b1;
          cnt_d = cnt_q + ONE;
          rem_d = rem_q - ONE;
          src_d = src_q + {{(AW-1){1'b0}}, sinc_q};
          dst_d = dst_q + {{(AW-1){1'b0}}, dinc_q};
          if (abort_q || ABORT) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else if (rem_q == ONE) begin
            state_d = S_FIN;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Gating with RESET keeps the responder from seeing a write in the reset cycle.
  assign bus.M_ADDR = addr_d;
  assign bus.M_DATA = data_q;
  assign bus.M_MW   = mw & ~RESET;

  assign BUSY  = (state_q == S_RD) || (state_q == S_WR);
  assign DONE  = (state_q == S_FIN);
  assign ERR   = err_q;
  assign COUNT = cnt_q;

endmodule

// File: tb/tb_mem_dma_master.sv
// Directed bench for mem_dma_master: table of transfers with a behavioural memory/MMIO
// responder, plus hand-written reset and power-on sequences.
module tb_mem_dma_master;

  logic       CLK = 1'b0;
  logic       RESET, START, ABORT, SRC_INC, DST_INC;
  logic [7:0] SRC, DST, LEN;
  logic       BUSY, DONE, ERR;
  logic [7:0] COUNT;

  mem_dma_master_if #(.AW(8), .DW(8)) bus ();

  mem_dma_master #(.AW(8), .DW(8), .IO_RO_LO(249), .IO_RO_HI(251)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT),
    .SRC(SRC), .DST(DST), .LEN(LEN), .SRC_INC(SRC_INC), .DST_INC(DST_INC),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .COUNT(COUNT), .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Responder model: RAM below 249, input ports 249..251, write-only ports read as 0.
  logic [7:0] mem [256];
  logic [7:0] io  [3];
  logic [7:0] q;
  always_comb begin
    q = 8'h00;
    if (bus.M_ADDR >= 8'd252)      q = 8'h00;
    else if (bus.M_ADDR >= 8'd249) q = io[bus.M_ADDR - 8'd249];
    else                           q = mem[bus.M_ADDR];
  end
  assign bus.M_Q = q;

  always @(posedge CLK) if (bus.M_MW) mem[bus.M_ADDR] = bus.M_DATA;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic init_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
    mem[4] = 8'h17;
    mem[5] = 8'h00;
    io[0] = 8'hA5; io[1] = 8'h3C; io[2] = 8'h5A;
  endtask

  typedef struct {
    logic [7:0] src, dst, len;
    logic       sinc, dinc;
    int         abort_cyc;
    int         exp_writes;
    logic [7:0] exp_count;
    logic       exp_err;
    int         exp_done;
    logic [7:0] f_addr, f_data, l_addr, l_data;
  } vec_t;

  vec_t vecs [8];

  task automatic run_vec(input int idx, input vec_t v);
    int c, done_c, nw;
    logic [7:0] fa, fd, la, ld;
    string tag;
    tag = $sformatf("v%0d", idx);
    init_mem();
    @(negedge CLK);
    SRC = v.src; DST = v.dst; LEN = v.len; SRC_INC = v.sinc; DST_INC = v.dinc;
    START = 1'b1; ABORT = (v.abort_cyc == 0);
    @(posedge CLK); #1;
    START = 1'b0; ABORT = 1'b0;
    c = 1; done_c = -1; nw = 0; fa = 0; fd = 0; la = 0; ld = 0;
    while (c <= 40 && done_c < 0) begin
      ABORT = (c == v.abort_cyc);
      @(negedge CLK);
      if (c == 1) chk({tag, "_busy1"}, BUSY, (v.len != 0));
      if (bus.M_MW) begin
        if (nw == 0) begin fa = bus.M_ADDR; fd = bus.M_DATA; end
        la = bus.M_ADDR; ld = bus.M_DATA;
        nw++;
      end
      if (DONE) begin
        done_c = c;
        chk({tag, "_busy_fin"}, BUSY, 0);
      end
      @(posedge CLK); #1;
      c++;
    end
    ABORT = 1'b0;
    chk({tag, "_timeout"}, (done_c < 0), 0);
    chk({tag, "_done_cyc"}, done_c, v.exp_done);
    chk({tag, "_count"}, COUNT, v.exp_count);
    chk({tag, "_err"}, ERR, v.exp_err);
    chk({tag, "_nwrites"}, nw, v.exp_writes);
    chk({tag, "_done_clr"}, DONE, 0);
    if (v.exp_writes > 0) begin
      chk({tag, "_first_addr"}, fa, v.f_addr);
      chk({tag, "_first_data"}, fd, v.f_data);
      chk({tag, "_last_addr"}, la, v.l_addr);
      chk({tag, "_last_data"}, ld, v.l_data);
    end
  endtask

  initial begin
    //           src    dst    len   si dinc abrt nw cnt err done  fA     fD     lA     lD
    vecs[0] = '{8'd4,  8'd252, 8'd2, 1, 1, -1, 2, 8'd2, 0, 5, 8'd252, 8'h17, 8'd253, 8'h00};
    vecs[1] = '{8'd249,8'd200, 8'd3, 0, 1, -1, 3, 8'd3, 0, 7, 8'd200, 8'hA5, 8'd202, 8'hA5};
    vecs[2] = '{8'd10, 8'd254, 8'd4, 1, 1, -1, 4, 8'd4, 0, 9, 8'd254, 8'hC9, 8'd1,   8'hCE};
    vecs[3] = '{8'd20, 8'd250, 8'd1, 1, 1, -1, 0, 8'd0, 1, 3, 8'd0,   8'h00, 8'd0,   8'h00};
    vecs[4] = '{8'd30, 8'd60,  8'd8, 1, 1,  5, 3, 8'd3, 1, 7, 8'd60,  8'hDD, 8'd62,  8'hE3};
    vecs[5] = '{8'd0,  8'd0,   8'd0, 1, 1, -1, 0, 8'd0, 0, 1, 8'd0,   8'h00, 8'd0,   8'h00};
    vecs[6] = '{8'd40, 8'd248, 8'd3, 1, 1, -1, 1, 8'd1, 1, 5, 8'd248, 8'hEB, 8'd248, 8'hEB};
    vecs[7] = '{8'd70, 8'd80,  8'd2, 1, 1,  0, 2, 8'd2, 0, 5, 8'd80,  8'h85, 8'd81,  8'h84};

    RESET = 1'b1; START = 1'b0; ABORT = 1'b0;
    SRC = '0; DST = '0; LEN = '0; SRC_INC = 1'b1; DST_INC = 1'b1;
    init_mem();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_addr", bus.M_ADDR, 0);
    chk("rst_data", bus.M_DATA, 0);
    chk("rst_mw", bus.M_MW, 0);
    RESET = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a 10-byte copy to 100..109.
    init_mem();
    @(negedge CLK);
    SRC = 8'd0; DST = 8'd100; LEN = 8'd10; SRC_INC = 1'b1; DST_INC = 1'b1; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (4) @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    chk("midrst_busy", BUSY, 0);
    chk("midrst_mw", bus.M_MW, 0);
    chk("midrst_count", COUNT, 0);
    chk("midrst_mem101", mem[101], 8'hC2);
    for (int a = 104; a <= 109; a++)
      chk($sformatf("midrst_mem%0d", a), mem[a], 8'(a) ^ 8'hC3);
    repeat (2) @(negedge CLK);
    chk("midrst_idle", BUSY, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_dma_master.md
Name: mem_dma_master

Overview:
- Bus-initiator block copy engine for the 8-bit data memory / memory-mapped IO responder.
- Sits between a host control interface and the responder's ADDR/DATA/MW/Q port.
- On START it copies LEN bytes from SRC to DST, one read then one write per byte. Examples: load a BCD lookup-table entry onto output ports 252-255, or sample input ports 249-251 into RAM.
- Source and destination address increment are selectable, so a fixed-port stream is supported.

Parameters:
- AW, 8, address width; the memory map assumes 256 locations.
- DW, 8, data word width.
- IO_RO_LO, 249, lowest read-only input-port address.
- IO_RO_HI, 251, highest read-only input-port address.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  one-cycle request; sampled only in IDLE.
- ABORT  input  1  stop the transfer after the current byte slot.
- SRC  input  AW  source start address, latched on START.
- DST  input  AW  destination start address, latched on START.
- LEN  input  AW  byte count, latched on START; 0 means no transfer.
- SRC_INC  input  1  1 = source address increments after each byte; 0 = fixed.
- DST_INC  input  1  1 = destination address increments after each byte; 0 = fixed.
- BUSY  output  1  high from the cycle after an accepted START until the DONE cycle.
- DONE  output  1  one-cycle completion pulse.
- ERR  output  1  sticky error flag; set on abort or read-only destination; cleared by the next accepted START.
- COUNT  output  AW  bytes written so far in the current or last transfer.
- M_ADDR  output  AW  address driven to the responder.
- M_DATA  output  DW  write data driven to the responder.
- M_MW  output  1  memory-write strobe to the responder.
- M_Q  input  DW  read data from the responder; combinational and valid in the same cycle M_ADDR is driven.

Behaviour:
- Reset values: state=IDLE, BUSY=0, DONE=0, ERR=0, COUNT=0, M_ADDR=0, M_DATA=0, M_MW=0.
- Reset is synchronous and overrides everything, including a transfer in progress. No write occurs in the reset cycle.
- States:
  - IDLE → RD on START. LEN and all address/mode inputs are latched; COUNT and ERR are cleared.
  - If START arrives with LEN=0, go IDLE → FIN directly. No bus activity occurs.
  - RD: drive M_ADDR=src_ptr, M_MW=0. At the clock edge capture M_Q into the data register. Next state is WR.
  - WR: drive M_ADDR=dst_ptr, M_DATA=data register, M_MW=1 for exactly this cycle.
    - At the edge: COUNT+1, remaining-1.
    - src_ptr+SRC_INC and dst_ptr+DST_INC, both modulo 256 (255 wraps to 0, no error).
    - Next state is FIN if remaining reaches 0 or ABORT was sampled during the transfer; otherwise RD.
  - FIN: DONE=1 for one cycle, BUSY=0. Next state is IDLE.
- Read-only destination:
  - If dst_ptr lies in IO_RO_LO..IO_RO_HI at entry to WR, assert M_MW=0 in that cycle.
  - Set ERR, do not increment COUNT, go to FIN.
- Reads of write-only ports (252-255) are not errors: the responder returns 0 and that value is copied.
- ABORT:
  - Sampled in RD or WR. The current byte completes its write; then go to FIN with ERR=1.
  - ABORT in IDLE is ignored.
- START while not IDLE is ignored.
- Simultaneous START and ABORT in IDLE: START is accepted and ABORT is ignored.
- Timing:
  - Throughput is 2 cycles per byte.
  - START at edge n gives the first RD cycle n+1 and the first write edge at n+2.
  - DONE is asserted in cycle n+2·LEN+1.
- Bus is idle (M_MW=0) in IDLE and FIN. M_ADDR holds its last value there.
- COUNT holds its value after DONE until the next accepted START.

Test Plan:
- Reset mid-transfer: START SRC=0 DST=100 LEN=10, assert RESET at cycle 5 → next cycle BUSY=0, M_MW=0, COUNT=0. mem[104..109] are unchanged.
- LUT copy: memory preloaded with mem[4]=0x17, mem[5]=0x00. START SRC=4 DST=252 LEN=2 with both increments on → M_MW pulses at ADDR 252 with data 0x17, then ADDR 253 with data 0x00. DONE occurs at cycle 5 after START; COUNT=2; ERR=0.
- Fixed-source stream: IOA=0xA5, START SRC=249 SRC_INC=0 DST=200 LEN=3 → mem[200..202]=0xA5 and COUNT=3.
- Wrap-around: START SRC=10 DST=254 LEN=4 DST_INC=1 → writes at 254, 255, 0, 1; no ERR.
- Read-only destination: START DST=250 LEN=1 → M_MW never asserts, ERR=1, DONE pulses, COUNT=0.
- ABORT and LEN=0:
  - START LEN=8, then ABORT during the third RD → exactly 3 writes, then DONE with ERR=1 and COUNT=3.
  - START LEN=0 → DONE the next cycle and no M_MW.
